// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM encoding and width helpers for mem_controller_n.
// Shared by the controller top and its request arbiter.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int lat);
      return (lat > 1) ? $clog2(lat + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_controller_n_arb.sv
// rr_arbiter: N-way request arbiter for mem_controller_n.
// MEMCTRL_RR_EN selects round-robin; otherwise fixed lowest-index priority.
module rr_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req_i,
   input  logic          advance_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic found;

`ifdef MEMCTRL_RR_EN
   logic [IW-1:0] ptr_q, ptr_d;

   // Indices above the pointer first, then wrap to the lowest index.
   always_comb begin
      found = 1'b0;
      idx_o = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (IW'(i) > ptr_q)) begin
            found = 1'b1;
            idx_o = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i]) begin
            found = 1'b1;
            idx_o = IW'(i);
         end
      end
      gnt_o = found ? (N'(1) << idx_o) : '0;
      ptr_d = advance_i ? idx_o : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= IW'(N - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic unused_ok;
   assign unused_ok = ^{clk, rst, advance_i};

   always_comb begin
      found = 1'b0;
      idx_o = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i]) begin
            found = 1'b1;
            idx_o = IW'(i);
         end
      end
      gnt_o = found ? (N'(1) << idx_o) : '0;
   end
`endif

endmodule

// File: rtl/mem_controller_n.sv
// mem_controller_n: N-channel arbiter onto one synchronous single-port RAM.
// Define MEMCTRL_RR_EN for round-robin arbitration (default fixed priority).
module mem_controller_n
   import mem_ctrl_pkg::*;
#(
   parameter int N      = 3,
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    rden,
   input  logic [N-1:0]    wren,
   input  logic [N*AW-1:0] Address,
   input  logic [N*DW-1:0] Din,
   input  logic [DW-1:0]   RAMq,
   output logic [N-1:0]    acq,
   output logic [N*DW-1:0] Dq,
   output logic [AW-1:0]   RAMAddress,
   output logic [DW-1:0]   RAMDin,
   output logic            RAMwren
);

   localparam int IW = idx_w(N);
   localparam int CW = cnt_w(RD_LAT);

   state_e          state_q, state_d;
   logic [IW-1:0]   g_q, g_d;
   logic            wr_q, wr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   din_q, din_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N*DW-1:0] dq_q, dq_d;

   logic [N-1:0]    req;
   logic [N-1:0]    gnt;
   logic [IW-1:0]   gnt_idx;
   logic            grant;

   assign req   = rden | wren;
   assign grant = (state_q == IDLE) && (|gnt);

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req),
      .advance_i (grant),
      .gnt_o     (gnt),
      .idx_o     (gnt_idx)
   );

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      din_d   = din_q;
      cnt_d   = cnt_q;
      dq_d    = dq_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               g_d     = gnt_idx;
               wr_d    = wren[gnt_idx];
               addr_d  = Address[gnt_idx*AW +: AW];
               din_d   = Din[gnt_idx*DW +: DW];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (wr_q) begin
               state_d = ACK;
            end else begin
               cnt_d   = CW'(RD_LAT);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == CW'(1)) begin
               dq_d[g_q*DW +: DW] = RAMq;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // RAM-side outputs come straight from the capture registers.
   assign acq        = (state_q == ACK) ? (N'(1) << g_q) : '0;
   assign RAMwren    = (state_q == ISSUE) && wr_q;
   assign RAMAddress = addr_q;
   assign RAMDin     = din_q;
   assign Dq         = dq_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         cnt_q   <= '0;
         dq_q    <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         cnt_q   <= cnt_d;
         dq_q    <= dq_d;
      end
   end

endmodule
